unidade_load_store: RTL and testbench

- Memory-access stage downstream of the immediate word-shifter.
- Takes the decoded lw/sw opcode, the base register value and the already word-aligned immediate (immediate >> 2 for lw/sw), and forms the word address.
- Runs a req/ack handshake with the data memory and stalls the processor until the access completes.
- Returns load data to the write-back path.

---
 rtl/unidade_load_store.sv | 109 ++++++++++
 tb/tb_unidade_load_store.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/unidade_load_store.sv
// Load/store memory-access stage: forms the word address, runs a req/ack handshake with data memory and stalls upstream.
// Define LOAD_STORE_TIMEOUT_EN to abort requests that wait TIMEOUT cycles without an ack and raise a sticky err.
module unidade_load_store #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        opcode,
  input  logic [DATA_W-1:0] base,
  input  logic [15:0]       immediate,
  input  logic [DATA_W-1:0] store_data,
  input  logic              valid_in,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              load_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state;
  logic              is_mem;
  logic              accept;
  logic              timeout_hit;
  logic              timed_out;
  logic [DATA_W-1:0] addr_sum;

  assign is_mem     = (opcode == OP_LW) || (opcode == OP_SW);
  assign accept     = (state == S_IDLE) && valid_in && is_mem;
  assign addr_sum   = base + DATA_W'(immediate);
  assign stall      = (state == S_REQ) || accept;
  assign mem_req    = (state == S_REQ);
  // mem_we doubles as the "access is a store" flag for the whole transaction
  assign load_valid = (state == S_DONE) && !mem_we && !timed_out;

`ifdef LOAD_STORE_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wait_cnt;

  assign timeout_hit = (state == S_REQ) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
      err       <= 1'b0;
    end else if (accept) begin
      wait_cnt  <= '0;
      timed_out <= 1'b0;
    end else if (timeout_hit) begin
      timed_out <= 1'b1;
      err       <= 1'b1;
    end else if ((state == S_REQ) && !mem_ack) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timed_out   = 1'b0;
  assign err         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      load_data <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            mem_addr <= addr_sum[ADDR_W-1:0];
            mem_we   <= (opcode == OP_SW);
            if (opcode == OP_SW) mem_wdata <= store_data;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          // a real ack always wins over a timeout in the same cycle
          if (mem_ack) begin
            if (!mem_we) load_data <= mem_rdata;
            state <= S_DONE;
          end else if (timeout_hit) begin
            if (!mem_we) load_data <= '0;
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_load_store.sv
// Randomized self-checking bench for unidade_load_store against a transaction-level reference model.
// Define LOAD_STORE_TIMEOUT_EN to also exercise the request timeout.
module tb_unidade_load_store;

  localparam logic [5:0] LW = 6'b100011;
  localparam logic [5:0] SW = 6'b101011;

  logic        clk;
  logic        rst_n;
  logic [5:0]  opcode;
  logic [31:0] base;
  logic [15:0] immediate;
  logic [31:0] store_data;
  logic        valid_in;
  logic        stall;
  logic [31:0] load_data;
  logic        load_valid;
  logic        mem_req;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_ld;
  logic [31:0] model_wdata;
  logic        model_err;

  unidade_load_store #(.DATA_W(32), .ADDR_W(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .base(base), .immediate(immediate),
    .store_data(store_data), .valid_in(valid_in), .stall(stall), .load_data(load_data),
    .load_valid(load_valid), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] rand_nonmem();
    logic [5:0] op;
    do op = 6'($urandom); while (op == LW || op == SW);
    return op;
  endfunction

  // one complete lw/sw transaction: accept, waits+1 REQ cycles (ack in the last), DONE
  task automatic do_op(input logic [5:0] op, input logic [31:0] b, input logic [15:0] im,
                       input logic [31:0] sd, input int waits, input logic [31:0] rd);
    logic        is_lw;
    logic [31:0] sum;
    logic [7:0]  exp_addr;
    is_lw    = (op == LW);
    sum      = b + {16'h0, im};
    exp_addr = sum[7:0];
    opcode = op; base = b; immediate = im; store_data = sd; valid_in = 1'b1;
    mem_ack = 1'b0;
    #3;
    check_val("stall_accept", stall, 1);
    check_val("req_in_idle", mem_req, 0);
    step();
    if (!is_lw) model_wdata = sd;
    valid_in = 1'b0; opcode = 6'($urandom); base = $urandom; immediate = 16'($urandom);
    store_data = $urandom;
    for (int i = 0; i <= waits; i++) begin
      mem_ack   = (i == waits);
      mem_rdata = (i == waits) ? rd : $urandom;
      #3;
      check_val("req", mem_req, 1);
      check_val("stall_req", stall, 1);
      check_val("addr", mem_addr, exp_addr);
      check_val("we", mem_we, !is_lw);
      check_val("wdata", mem_wdata, model_wdata);
      check_val("lv_req", load_valid, 0);
      step();
    end
    mem_ack = 1'b0;
    if (is_lw) model_ld = rd;
    #3;
    check_val("stall_done", stall, 0);
    check_val("req_done", mem_req, 0);
    check_val("load_valid", load_valid, is_lw);
    check_val("load_data", load_data, model_ld);
    check_val("err", err, model_err);
    step();
  endtask

  task automatic nonmem_cycle();
    opcode = rand_nonmem(); valid_in = 1'b1; base = $urandom; immediate = 16'($urandom);
    mem_ack = 1'b1; mem_rdata = $urandom;
    #3;
    check_val("stall_nonmem", stall, 0);
    check_val("req_nonmem", mem_req, 0);
    check_val("lv_nonmem", load_valid, 0);
    step();
    mem_ack = 1'b0; valid_in = 1'b0;
    #3;
    check_val("req_after_stray", mem_req, 0);
    check_val("ld_after_stray", load_data, model_ld);
  endtask

  initial begin
    rst_n = 1'b0; opcode = LW; valid_in = 1'b1; base = 32'h10; immediate = 16'h3;
    store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    model_ld = '0; model_wdata = '0; model_err = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_val("rst_req", mem_req, 0);
      check_val("rst_lv", load_valid, 0);
      check_val("rst_we", mem_we, 0);
      check_val("rst_addr", mem_addr, 0);
      check_val("rst_wdata", mem_wdata, 0);
      check_val("rst_ld", load_data, 0);
      check_val("rst_err", err, 0);
    end
    valid_in = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    #3;
    check_val("post_rst_stall", stall, 0);
    check_val("post_rst_req", mem_req, 0);
    step();

    do_op(LW, 32'h10, 16'h3, 32'h0, 0, 32'hCAFEF00D);
    do_op(SW, 32'hFE, 16'h5, 32'h12345678, 3, 32'h0);
    nonmem_cycle();
    step();

    // reset in the middle of a load, ack arriving after release
    opcode = LW; valid_in = 1'b1; base = 32'h40; immediate = 16'h1;
    step();
    valid_in = 1'b0;
    step();
    rst_n = 1'b0;
    step();
    model_ld = '0; model_wdata = '0; model_err = 1'b0;
    #3;
    check_val("midrst_req", mem_req, 0);
    check_val("midrst_stall", stall, 0);
    check_val("midrst_lv", load_valid, 0);
    step();
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    #3;
    check_val("late_ack_req", mem_req, 0);
    check_val("late_ack_lv", load_valid, 0);
    step();
    mem_ack = 1'b0;
    #3;
    check_val("late_ack_lv2", load_valid, 0);
    check_val("late_ack_ld", load_data, 0);
    step();

    for (int n = 0; n < 30; n++) begin
      int kind;
      kind = $urandom_range(0, 4);
      if (kind == 0) nonmem_cycle();
      else do_op((kind < 3) ? LW : SW, $urandom, 16'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom);
    end

`ifdef LOAD_STORE_TIMEOUT_EN
    opcode = LW; valid_in = 1'b1; base = 32'h7; immediate = 16'h2; mem_ack = 1'b0;
    step();
    valid_in = 1'b0;
    for (int i = 0; i < 15; i++) begin
      #3;
      check_val("to_req", mem_req, 1);
      step();
    end
    model_ld = '0; model_err = 1'b1;
    #3;
    check_val("to_req_done", mem_req, 0);
    check_val("to_lv", load_valid, 0);
    check_val("to_err", err, 1);
    check_val("to_ld", load_data, 0);
    step();
    do_op(LW, $urandom, 16'($urandom), 32'h0, 0, 32'h5A5A1234);
    #3;
    check_val("err_sticky", err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
